// File: rtl/spi_pkg.sv
// Shared definitions for the system SPI slave.
// Register map, status bit positions and FSM states.
package spi_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int SB_ROE  = 3;
  localparam int SB_TOE  = 4;
  localparam int SB_TUE  = 5;
  localparam int SB_TRDY = 6;
  localparam int SB_RRDY = 7;
  localparam int SB_E    = 8;

  // Only the interrupt-enable bits 8..3 are stored.
  localparam logic [15:0] CTL_MASK = 16'h01F8;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  function automatic logic [15:0] status_word(
    input logic rrdy,
    input logic trdy,
    input logic tue,
    input logic toe,
    input logic roe
  );
    logic [15:0] s;
    s          = '0;
    s[SB_ROE]  = roe;
    s[SB_TOE]  = toe;
    s[SB_TUE]  = tue;
    s[SB_TRDY] = trdy;
    s[SB_RRDY] = rrdy;
    s[SB_E]    = roe | toe | tue;
    return s;
  endfunction

endpackage

// File: rtl/system_spi_slave_edge_sync.sv
// Synchronizer chain plus history flop for one async input.
// Provides the synchronized level and one-cycle rise/fall pulses.
module spi_edge_sync #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] sync_d;
  logic                  hist_q;
  logic                  hist_d;

  // Shift the raw input in; remember the previous synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], din};
    hist_d = sync_q[SYNC_DEPTH-1];
  end

  // Clearing to 0 means a line held low across reset never fakes a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SYNC_DEPTH-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/system_spi_slave.sv
// SPI mode-0 slave with the master's CPU register layout.
// Oversampled SPI pins, rx/tx holding registers, status and irq.
module system_spi_slave
  import spi_pkg::*;
#(
  parameter int DATABITS   = 8,
  parameter int SYNC_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq
);

  if (DATABITS != 8) begin : g_bad_databits
    $error("system_spi_slave: DATABITS must be 8");
  end
  if (SYNC_DEPTH < 2) begin : g_bad_sync
    $error("system_spi_slave: SYNC_DEPTH must be >= 2");
  end

  localparam int CW = $clog2(DATABITS) + 1;
  localparam int PADW = 16 - DATABITS;

  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;
  logic mosi_lvl;
  logic unused_sclk_lvl;
  logic unused_ss_lvl;
  logic unused_mosi_rise;
  logic unused_mosi_fall;

  spi_edge_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (SCLK),
    .level (unused_sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_edge_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_ss (
    .clk   (clk),
    .reset (reset),
    .din   (SS_n),
    .level (unused_ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_edge_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (MOSI),
    .level (mosi_lvl),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  logic rd_req;
  logic wr_req;
  logic rd_hold_q, rd_hold_d;
  logic wr_hold_q, wr_hold_d;
  logic rd_stb_q, rd_stb_d;
  logic wr_stb_q, wr_stb_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  assign rd_req = spi_select & ~read_n;
  assign wr_req = spi_select & ~write_n;

  // One strobe per access; address and data captured with it.
  always_comb begin
    rd_hold_d = rd_req;
    wr_hold_d = wr_req;
    rd_stb_d  = rd_req & ~rd_hold_q;
    wr_stb_d  = wr_req & ~wr_hold_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (rd_stb_d | wr_stb_d) begin
      addr_d  = mem_addr;
      wdata_d = data_from_cpu;
    end
  end

  logic rd_clr;
  logic tx_wr;
  logic st_wr;
  logic ctl_wr;

  assign rd_clr = rd_stb_q & (addr_q == ADDR_RXDATA);
  assign tx_wr  = wr_stb_q & (addr_q == ADDR_TXDATA);
  assign st_wr  = wr_stb_q & (addr_q == ADDR_STATUS);
  assign ctl_wr = wr_stb_q & (addr_q == ADDR_CONTROL);

  state_e              state_q, state_d;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic [DATABITS-1:0] shift_q, shift_d;
  logic [DATABITS-1:0] rx_q, rx_d;
  logic [DATABITS-1:0] tx_q, tx_d;
  logic                mosi_bit_q, mosi_bit_d;
  logic                primed_q, primed_d;
  logic                pend_q, pend_d;
  logic                rrdy_q, rrdy_d;
  logic                roe_q, roe_d;
  logic                toe_q, toe_d;
  logic                tue_q, tue_d;
  logic [15:0]         ctl_q, ctl_d;
  logic [15:0]         dout_q, dout_d;
  logic                irq_q, irq_d;
  logic                rx_done;
  logic                load;
  logic [15:0]         stat;

  assign stat = status_word(rrdy_q, ~primed_q, tue_q, toe_q, roe_q);

  // Frame FSM, shifter, holding registers and status flags.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    mosi_bit_d = mosi_bit_q;
    primed_d   = primed_q;
    pend_d     = pend_q;
    rrdy_d     = rrdy_q;
    roe_d      = roe_q;
    toe_d      = toe_q;
    tue_d      = tue_q;
    rx_done    = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          state_d  = S_ACTIVE;
          bitcnt_d = '0;
          pend_d   = 1'b0;
          load     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ss_rise) begin
          state_d  = S_IDLE;
          bitcnt_d = '0;
          pend_d   = 1'b0;
        end else begin
          if (sclk_rise) begin
            mosi_bit_d = mosi_lvl;
            if (bitcnt_q == CW'(DATABITS - 1)) begin
              rx_d     = {shift_q[DATABITS-2:0], mosi_lvl};
              rx_done  = 1'b1;
              bitcnt_d = '0;
              pend_d   = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + CW'(1);
            end
          end
          if (sclk_fall) begin
            if (pend_q) begin
              load   = 1'b1;
              pend_d = 1'b0;
            end else begin
              shift_d = {shift_q[DATABITS-2:0], mosi_bit_q};
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d  = primed_q ? tx_q : '0;
      primed_d = 1'b0;
      if (!primed_q) tue_d = 1'b1;
    end
    if (rx_done && rrdy_q && !rd_clr) roe_d = 1'b1;
    // A reload in the same cycle frees the holding register.
    if (tx_wr) begin
      if (!primed_q || load) begin
        tx_d     = wdata_q[DATABITS-1:0];
        primed_d = 1'b1;
      end else begin
        toe_d = 1'b1;
      end
    end
    if (rd_clr) rrdy_d = 1'b0;
    if (st_wr) begin
      rrdy_d = 1'b0;
      roe_d  = 1'b0;
      toe_d  = 1'b0;
      tue_d  = 1'b0;
    end
    if (rx_done) rrdy_d = 1'b1;
  end

  // Read data mux, control register and interrupt.
  always_comb begin
    dout_d = dout_q;
    ctl_d  = ctl_q;
    if (rd_stb_q) begin
      case (addr_q)
        ADDR_RXDATA:  dout_d = {{PADW{1'b0}}, rx_q};
        ADDR_TXDATA:  dout_d = {{PADW{1'b0}}, tx_q};
        ADDR_STATUS:  dout_d = stat;
        ADDR_CONTROL: dout_d = ctl_q;
        default:      dout_d = '0;
      endcase
    end
    if (ctl_wr) ctl_d = wdata_q & CTL_MASK;
    irq_d = |(stat & ctl_q);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hold_q  <= 1'b0;
      wr_hold_q  <= 1'b0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      mosi_bit_q <= 1'b0;
      primed_q   <= 1'b0;
      pend_q     <= 1'b0;
      rrdy_q     <= 1'b0;
      roe_q      <= 1'b0;
      toe_q      <= 1'b0;
      tue_q      <= 1'b0;
      ctl_q      <= '0;
      dout_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      rd_hold_q  <= rd_hold_d;
      wr_hold_q  <= wr_hold_d;
      rd_stb_q   <= rd_stb_d;
      wr_stb_q   <= wr_stb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      mosi_bit_q <= mosi_bit_d;
      primed_q   <= primed_d;
      pend_q     <= pend_d;
      rrdy_q     <= rrdy_d;
      roe_q      <= roe_d;
      toe_q      <= toe_d;
      tue_q      <= tue_d;
      ctl_q      <= ctl_d;
      dout_q     <= dout_d;
      irq_q      <= irq_d;
    end
  end

  assign MISO        = shift_q[DATABITS-1];
  assign MISO_oe     = (state_q == S_ACTIVE);
  assign data_to_cpu = dout_q;
  assign irq         = irq_q;

endmodule
